cdc_multi_event_receiver: RTL and testbench
===========================================

Name: cdc_multi_event_receiver

Overview:
Receiving-side endpoint for CHANNELS independent 2-phase toggle signals that arrive from foreign clock domains or pins. Each toggle change is one event.
Per channel, the block synchronises the toggle, converts each edge to a single-cycle pulse, and counts events not yet consumed in a saturating counter. Pending events are presented one at a time on a valid/ready event port with round-robin fairness, so back-to-back events are never lost to a slow consumer.
Sits in the receiving clock domain; the matching senders keep plain toggle flops that reset to 0.

Parameters:
CHANNELS, 4, number of independent toggle inputs (>=1)
CDC_EXTRA_DEPTH, 0, extra synchroniser stages beyond 2; total stages S = 2 + CDC_EXTRA_DEPTH
COUNT_WIDTH, 4, width of each per-channel pending-event counter; maximum count is 2^COUNT_WIDTH-1
CHANNEL_INDEX_WIDTH, clog2(CHANNELS) (min 1), width of event_channel

Ports:
clock  in  1  receiving clock
reset  in  1  asynchronous, active-high reset
toggle_in  in  CHANNELS  asynchronous 2-phase event toggles, one bit per channel
pulse_out  out  CHANNELS  one-cycle pulse per synchronised toggle edge (raw, not flow-controlled)
event_valid  out  1  at least one event is pending and is presented
event_ready  in  1  consumer accepts the presented event
event_channel  out  CHANNEL_INDEX_WIDTH  channel index of the presented event
pending_any  out  CHANNELS  per-channel "counter non-zero"
overflow  out  CHANNELS  sticky flag: an event was dropped at saturation
overflow_clear  in  CHANNELS  per-channel clear of the overflow flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. All flops take reset directly.
- Reset values:
  - sync chains, edge-detect history, counters, overflow, lock and pointer: 0.
  - pulse_out, event_valid, pending_any and overflow read 0; event_channel reads 0.
- Reset mid-operation discards all pending events. No pulse is produced on reset release while the inputs are 0.
- Synchroniser: each toggle_in bit passes through S flops.
- Pulse generation: pulse_out[c] = sync_out[c] XOR last_sync[c], with last_sync registered.
  - A toggle change stable before edge k gives pulse_out high between edges k+S-1 and k+S.
- Counter update at edge k+S:
  - increment only: +1
  - handshake (event_valid && event_ready) on c only: -1
  - both on the same channel in the same cycle: unchanged
  - increment while count == max: count held, overflow[c] set
- overflow[c] is sticky. overflow_clear[c] clears it; if set and clear occur in the same cycle, set wins.
- Minimum latency from toggle edge to event_valid is S+1 edges, when the counter was 0 and the port was idle.
- Arbitration:
  - When the port is idle, the winner is the first channel with count != 0, searching from rr_pointer upward with wrap-around.
  - The winner is registered in a lock flop (event_channel), and event_valid is driven from registered state.
  - While event_valid && !event_ready, event_channel and event_valid are held; newly pending channels never preempt.
  - On a handshake for channel c, rr_pointer becomes (c+1) mod CHANNELS.
  - On the cycle after a handshake, a new winner may be presented. Sustained throughput is 1 event per 2 cycles.
- Counts are consumed only by handshakes, so a presented channel always has count >= 1.
- CHANNELS == 1: arbitration is trivial and event_channel is always 0.
- toggle_in changes narrower than one clock period may be missed. That is the sender's contract: hold each toggle level for at least S+1 receiving cycles; rate beyond that is absorbed by the counters.

Decomposition:
- Shared package cdc_pkg: function clog2_min1; the S = 2 + CDC_EXTRA_DEPTH stage-count constant.
- Per-channel synchronisation reuses the existing cdc_bit_synchronizer and pulse_generator (anyedge output) inside a generate loop.
- One new sub-module, arbiter_round_robin: inputs requests[CHANNELS] and pointer; outputs a one-hot grant and its index. It is combinational and parameterised by CHANNELS.
- Counters, lock register and pointer live in the top module.

Test Plan:
1. Reset release with toggle_in=0000 -> no pulse_out, event_valid=0 for 20 cycles; all outputs 0.
2. Flip toggle_in[2] once, S=2, event_ready=1 -> pulse_out[2] high for exactly 1 cycle two edges later. event_valid rises on the next edge with event_channel=2, and the count returns to 0 after the handshake.
3. Flip toggle_in[1] 3 times, each 4 cycles apart, event_ready=0 -> pending_any[1]=1 and the count reaches 3. Then raise ready -> exactly 3 handshakes with channel=1, then event_valid=0.
4. Set counts ch0=2, ch3=1, ch1=1 with ready=0, then ready=1 -> handshake order 0,1,3,0; event_channel is stable during stalls.
5. COUNT_WIDTH=2, 5 flips on ch0 with ready=0 -> count saturates at 3 and overflow[0]=1. Pulse overflow_clear[0] together with a 6th flip -> overflow stays 1; a later lone clear -> 0.
6. Assert reset asynchronously (between edges) with counts pending -> all outputs drop immediately. After release with toggles held -> no spurious events.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the clock-domain-crossing receive blocks.
package cdc_pkg;

    localparam int CDC_BASE_STAGES = 2;

    function automatic int cdc_stages(input int extra_depth);
        return CDC_BASE_STAGES + extra_depth;
    endfunction

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/arbiter_round_robin.sv
// Combinational round-robin pick: first request at or above pointer, with wrap-around.
module arbiter_round_robin #(
    parameter int CHANNELS    = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [CHANNELS-1:0]    requests,
    input  logic [INDEX_WIDTH-1:0] pointer,
    output logic [CHANNELS-1:0]    grant,
    output logic [INDEX_WIDTH-1:0] grant_index
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        logic found;
        int   idx;
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        idx         = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = (int'(pointer) + i) % CHANNELS;
            if (!found && requests[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_index = INDEX_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/cdc_bit_synchronizer.sv
// Multi-flop synchroniser for one asynchronous bit; output is the last stage.
module cdc_bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic data_in,
    output logic data_out
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], data_in};
        end
    end

    assign data_out = chain[STAGES-1];

endmodule

// File: rtl/pulse_generator.sv
// Converts any edge of a synchronised level into a one-cycle pulse.
module pulse_generator (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic anyedge
);

    logic last_level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_level <= 1'b0;
        end else begin
            last_level <= level;
        end
    end

    assign anyedge = level ^ last_level;

endmodule

// File: rtl/cdc_multi_event_receiver.sv
// Receives CHANNELS 2-phase toggles, counts their events and serves them
// one at a time on a round-robin valid/ready port.
module cdc_multi_event_receiver
    import cdc_pkg::*;
#(
    parameter int CHANNELS            = 4,
    parameter int CDC_EXTRA_DEPTH     = 0,
    parameter int COUNT_WIDTH         = 4,
    parameter int CHANNEL_INDEX_WIDTH = clog2_min1(CHANNELS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            toggle_in,
    output logic [CHANNELS-1:0]            pulse_out,
    output logic                           event_valid,
    input  logic                           event_ready,
    output logic [CHANNEL_INDEX_WIDTH-1:0] event_channel,
    output logic [CHANNELS-1:0]            pending_any,
    output logic [CHANNELS-1:0]            overflow,
    input  logic [CHANNELS-1:0]            overflow_clear
);

    localparam int SYNC_STAGES = cdc_stages(CDC_EXTRA_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [CHANNELS-1:0]            sync_out;
    logic [CHANNELS-1:0]            pulse;
    logic [CHANNELS-1:0]            requests;
    logic [CHANNELS-1:0]            grant;
    logic [CHANNEL_INDEX_WIDTH-1:0] grant_index;
    logic                           lock_valid;
    logic [CHANNEL_INDEX_WIDTH-1:0] lock_channel;
    logic [CHANNEL_INDEX_WIDTH-1:0] rr_pointer;
    logic [CHANNEL_INDEX_WIDTH-1:0] next_pointer;
    logic                           handshake;

    assign handshake = lock_valid && event_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
        logic [COUNT_WIDTH-1:0] count;
        logic                   overflow_q;
        logic                   take;
        logic                   drop;

        cdc_bit_synchronizer #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clock    (clock),
            .reset    (reset),
            .data_in  (toggle_in[c]),
            .data_out (sync_out[c])
        );

        pulse_generator u_pulse (
            .clock   (clock),
            .reset   (reset),
            .level   (sync_out[c]),
            .anyedge (pulse[c])
        );

        assign take = handshake && (lock_channel == CHANNEL_INDEX_WIDTH'(c));
        // An event is lost only when it would raise an already-full count.
        assign drop = pulse[c] && !take && (count == COUNT_MAX);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                count      <= '0;
                overflow_q <= 1'b0;
            end else begin
                case ({pulse[c], take})
                    2'b10:   if (count != COUNT_MAX) count <= count + COUNT_WIDTH'(1);
                    2'b01:   count <= count - COUNT_WIDTH'(1);
                    default: ;
                endcase
                overflow_q <= drop || (overflow_q && !overflow_clear[c]);
            end
        end

        assign requests[c] = (count != '0);
        assign overflow[c] = overflow_q;
    end

    arbiter_round_robin #(
        .CHANNELS    (CHANNELS),
        .INDEX_WIDTH (CHANNEL_INDEX_WIDTH)
    ) u_arbiter (
        .requests    (requests),
        .pointer     (rr_pointer),
        .grant       (grant),
        .grant_index (grant_index)
    );

    assign next_pointer = (lock_channel == CHANNEL_INDEX_WIDTH'(CHANNELS - 1))
                        ? '0 : lock_channel + CHANNEL_INDEX_WIDTH'(1);

    // The lock holds the presented channel until it is consumed; no preemption.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_valid   <= 1'b0;
            lock_channel <= '0;
            rr_pointer   <= '0;
        end else if (lock_valid) begin
            if (event_ready) begin
                lock_valid <= 1'b0;
                rr_pointer <= next_pointer;
            end
        end else if (|grant) begin
            lock_valid   <= 1'b1;
            lock_channel <= grant_index;
        end
    end

    assign pulse_out     = pulse;
    assign pending_any   = requests;
    assign event_valid   = lock_valid;
    assign event_channel = lock_channel;

endmodule

// File: tb/tb_cdc_multi_event_receiver.sv
// Randomised scoreboard bench for cdc_multi_event_receiver against a per-channel
// event-count model built from the block's documented rules.
module tb_cdc_multi_event_receiver;

    localparam int CH   = 4;
    localparam int XD   = 0;
    localparam int CW   = 2;
    localparam int IW   = 2;
    localparam int S    = 2 + XD;
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] toggle_in;
    logic [CH-1:0] pulse_out;
    logic          event_valid;
    logic          event_ready;
    logic [IW-1:0] event_channel;
    logic [CH-1:0] pending_any;
    logic [CH-1:0] overflow;
    logic [CH-1:0] overflow_clear;

    cdc_multi_event_receiver #(
        .CHANNELS            (CH),
        .CDC_EXTRA_DEPTH     (XD),
        .COUNT_WIDTH         (CW),
        .CHANNEL_INDEX_WIDTH (IW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .toggle_in      (toggle_in),
        .pulse_out      (pulse_out),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_channel  (event_channel),
        .pending_any    (pending_any),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int due;
        int ch;
    } pulse_t;

    pulse_t pulse_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Reference model: pending events per channel, sticky drop flags, fairness pointer.
    int mcount[CH];
    int pcount[CH];
    bit movf[CH];
    int mptr, pptr;
    bit pv, pready;
    int pch;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mcount[c] = 0;
            pcount[c] = 0;
            movf[c]   = 1'b0;
        end
        mptr   = 0;
        pptr   = 0;
        pv     = 1'b0;
        pready = 1'b0;
        pch    = 0;
        pulse_q.delete();
    endtask

    always @(negedge clock) begin
        logic [CH-1:0] exp_pulse;
        logic [CH-1:0] exp_pend;
        logic [CH-1:0] exp_ovf;
        bit ev, hs;
        int ech;
        if (reset) begin
            model_reset();
        end else begin
            exp_pulse = '0;
            while (pulse_q.size() > 0 && pulse_q[0].due == cyc) begin
                pulse_t e;
                e = pulse_q.pop_front();
                exp_pulse[e.ch] = 1'b1;
            end
            check("pulse_out", 32'(pulse_out), 32'(exp_pulse));

            for (int c = 0; c < CH; c++) begin
                exp_pend[c] = (mcount[c] != 0);
                exp_ovf[c]  = movf[c];
            end
            check("pending_any", 32'(pending_any), 32'(exp_pend));
            check("overflow", 32'(overflow), 32'(exp_ovf));

            ev  = 1'b0;
            ech = 0;
            if (pv && !pready) begin
                ev  = 1'b1;
                ech = pch;
            end else if (!pv) begin
                for (int i = 0; i < CH; i++) begin
                    int idx;
                    idx = (pptr + i) % CH;
                    if (!ev && pcount[idx] != 0) begin
                        ev  = 1'b1;
                        ech = idx;
                    end
                end
            end
            check("event_valid", 32'(event_valid), 32'(ev));
            if (ev) check("event_channel", 32'(event_channel), 32'(ech));

            hs = ev && event_ready;
            pv     = ev;
            pch    = ech;
            pready = event_ready;
            pptr   = mptr;
            for (int c = 0; c < CH; c++) begin
                bit inc, dec, dropped;
                pcount[c] = mcount[c];
                inc     = exp_pulse[c];
                dec     = hs && (ech == c);
                dropped = 1'b0;
                if (inc && !dec) begin
                    if (mcount[c] == MAXC) dropped = 1'b1;
                    else mcount[c]++;
                end else if (dec && !inc) begin
                    mcount[c]--;
                end
                movf[c] = dropped || (movf[c] && !overflow_clear[c]);
            end
            if (hs) mptr = (ech + 1) % CH;
        end
    end

    logic [CH-1:0] tog;
    int last_flip[CH];

    task automatic step(input logic [CH-1:0] force_mask, input int flip_pct,
                        input int ready_pct, input int clear_pct);
        @(posedge clock);
        #1;
        for (int c = 0; c < CH; c++) begin
            bool_flip: begin
                bit want;
                want = force_mask[c] ||
                       (($urandom_range(99) < flip_pct) && (cyc - last_flip[c] >= S + 1));
                if (want) begin
                    tog[c]       = ~tog[c];
                    last_flip[c] = cyc;
                    pulse_q.push_back('{due: cyc + S, ch: c});
                end
            end
            overflow_clear[c] = ($urandom_range(99) < clear_pct);
        end
        event_ready = ($urandom_range(99) < ready_pct);
        toggle_in   = tog;
    endtask

    initial begin
        reset          = 1'b1;
        toggle_in      = '0;
        event_ready    = 1'b0;
        overflow_clear = '0;
        tog            = '0;
        for (int c = 0; c < CH; c++) last_flip[c] = -100;
        model_reset();

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        repeat (20) step('0, 0, 100, 0);
        step(4'b0100, 0, 100, 0);
        repeat (10) step('0, 0, 100, 0);
        step(4'b0010, 0, 0, 0);
        repeat (4) step('0, 0, 0, 0);
        step(4'b0010, 0, 0, 0);
        repeat (4) step('0, 0, 0, 0);
        step(4'b0010, 0, 0, 0);
        repeat (8) step('0, 0, 0, 0);
        repeat (10) step('0, 0, 100, 0);

        repeat (60) step('0, 35, 0, 0);
        repeat (60) step('0, 0, 40, 10);
        repeat (300) step('0, 20, 50, 5);
        repeat (30) step('0, 40, 0, 3);

        @(posedge clock);
        #3;
        reset          = 1'b1;
        tog            = '0;
        toggle_in      = '0;
        event_ready    = 1'b0;
        overflow_clear = '0;
        #1;
        check("reset_pulse_out", 32'(pulse_out), 32'd0);
        check("reset_event_valid", 32'(event_valid), 32'd0);
        check("reset_event_channel", 32'(event_channel), 32'd0);
        check("reset_pending_any", 32'(pending_any), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int c = 0; c < CH; c++) last_flip[c] = cyc;

        repeat (20) step('0, 0, 100, 0);
        repeat (200) step('0, 25, 70, 5);
        repeat (40) step('0, 0, 100, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
